fetch_wait_stage: RTL
=====================

FETCH_WAIT_STAGE -- requirements
Module: fetch_wait_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 valid_i  input  1  fetch stage presents one entry: an accepted instruction request or a fetch exception.
REQ-004 pc_i  input  32  PC of the presented entry.
REQ-005 cancelled_i  input  1  presented entry belongs to a flushed path; its data, if any, is dropped.
REQ-006 exc_i  input  1  entry carries a fetch exception; no memory data follows.
REQ-007 exc_miss_i  input  1  exception is a TLB refill miss.
REQ-008 exccode_i  input  5  exception code of the entry.
REQ-009 ready_o  output  1  this stage accepts the presented entry this cycle.
REQ-010 inst_data_ok  input  1  memory returns data for the oldest outstanding instruction request.
REQ-011 inst_rdata  input  32  returned instruction word, valid when inst_data_ok=1.
REQ-012 ready_i  input  1  decode stage accepts the output this cycle.
REQ-013 valid_o  output  1  output entry valid.
REQ-014 pc_o  output  32  output PC.
REQ-015 inst_o  output  32  output instruction word; 0 for exception entries.
REQ-016 exc_o / exc_miss_o / exccode_o  output  1/1/5  exception fields of output entry.
REQ-017 commit_i  input  1  pipeline flush (exception/ERET commit).
REQ-018 perfcnt_fetch_waitdata  output  32  count of cycles spent waiting for instruction data.

Function
REQ-019 State machine, 2 bits: EMPTY (no entry), WAIT (request outstanding, data not yet returned), HOLD (entry complete, stalled by decode), DISCARD (outstanding request whose data is to be dropped).
REQ-020 Entry register holds pc, exc, exc_miss, exccode, inst; loaded on accept; inst loaded on data capture.
REQ-021 ready_o = EMPTY || (WAIT && inst_data_ok && ready_i) || (HOLD && ready_i) || (DISCARD && inst_data_ok).
REQ-022 Accept = valid_i && ready_o; next state on accept: commit_i or cancelled_i -> DISCARD if !exc_i, else EMPTY (entry dropped); otherwise exc_i -> HOLD, else WAIT.
REQ-023 WAIT with inst_data_ok: valid_o=1 same cycle, inst_o=inst_rdata bypassed combinationally (zero-cycle latency); ready_i=0 -> capture inst_rdata, go HOLD; ready_i=1 and no accept -> EMPTY.
REQ-024 WAIT without inst_data_ok: valid_o=0, remain WAIT; perfcnt increments by 1.
REQ-025 HOLD: valid_o=1, inst_o=held word; ready_i=1 and no accept -> EMPTY; ready_i=0 -> stay.
REQ-026 DISCARD: valid_o=0; inst_data_ok drops the word and -> EMPTY unless a new entry is accepted the same cycle (REQ-022).
REQ-027 commit_i forces valid_o=0 that cycle; WAIT without data_ok -> DISCARD; WAIT with data_ok or HOLD -> old entry dropped; DISCARD unchanged; accepted entry handled per REQ-022.
REQ-028 At most one instruction request outstanding; inst_data_ok in EMPTY or HOLD is a protocol violation, ignored with no state change.
REQ-029 pc_o/exc fields reflect entry register whenever valid_o=1; undefined-but-stable otherwise.
REQ-030 perfcnt wraps modulo 2^32.

Reset
REQ-031 reset=1 on a clock edge: state=EMPTY, entry register=0, perfcnt=0; valid_o=0, ready_o=1 in the following cycle; reset takes priority over every other input, including mid-WAIT/DISCARD (any later data_ok from memory is then ignored per REQ-028).

Verification
REQ-032 Accept pc_i=0xBFC00000, data_ok two cycles later with inst_rdata=0x3C1D8000, ready_i=1 -> valid_o=1 in that cycle, inst_o=0x3C1D8000, perfcnt=2.
REQ-033 Same as REQ-032 with ready_i=0 for three cycles -> HOLD, valid_o=1 with stable inst_o for 3 cycles, ready_o=0, EMPTY after ready_i rises.
REQ-034 Accept exc_i=1, exccode_i=4 (AdEL), pc_i=0x80000001 -> next cycle valid_o=1, exc_o=1, exccode_o=4, inst_o=0, no data_ok needed.
REQ-035 Accept pc 0x80001000, assert commit_i before data_ok, then data_ok with 0x12345678 -> valid_o never 1, state EMPTY afterwards.
REQ-036 Back-to-back: data_ok in WAIT with ready_i=1 and new valid_i accepted same cycle -> first word output, second entry in WAIT next cycle, no bubble on ready_o.
REQ-037 Accept with cancelled_i=1, then data_ok -> word dropped, valid_o stays 0, ready_o=1 during data_ok cycle.

Source files
------------

// File: rtl/fetch_wait_stage_if.sv
// Bundles the fetch-side entry, memory return, decode handshake and flush signals of the fetch wait stage.
// Pure wiring: no latency of its own.
// Backpressure is carried by ready_o (towards fetch) and ready_i (from decode).
interface fetch_wait_stage_if;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        cancelled_i;
    logic        exc_i;
    logic        exc_miss_i;
    logic [4:0]  exccode_i;
    logic        ready_o;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        exc_o;
    logic        exc_miss_o;
    logic [4:0]  exccode_o;
    logic        commit_i;
    logic [31:0] perfcnt_fetch_waitdata;

    modport slave (
        input  valid_i, pc_i, cancelled_i, exc_i, exc_miss_i, exccode_i,
        input  inst_data_ok, inst_rdata, ready_i, commit_i,
        output ready_o, valid_o, pc_o, inst_o, exc_o, exc_miss_o, exccode_o,
        output perfcnt_fetch_waitdata
    );

    modport master (
        output valid_i, pc_i, cancelled_i, exc_i, exc_miss_i, exccode_i,
        output inst_data_ok, inst_rdata, ready_i, commit_i,
        input  ready_o, valid_o, pc_o, inst_o, exc_o, exc_miss_o, exccode_o,
        input  perfcnt_fetch_waitdata
    );
endinterface

// File: rtl/fetch_wait_stage.sv
// Holds one fetch entry while its instruction word returns from memory, then hands it to decode.
// Latency: returned word is bypassed to the output in the same cycle; exception entries appear one cycle after accept.
// Backpressure: ready_o only when the slot will be free this cycle; a stalled word is parked in HOLD.
module fetch_wait_stage (
    input  logic              clk,
    input  logic              reset,
    fetch_wait_stage_if.slave io
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        exc;
        logic        exc_miss;
        logic [4:0]  exccode;
        logic [31:0] inst;
    } entry_t;

    state_e      state_q, state_d;
    entry_t      entry_q, entry_d;
    logic [31:0] perf_q,  perf_d;
    logic        rdy;
    logic        vld;
    logic [31:0] inst_out;
    logic        accept;

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        perf_d   = perf_q;
        rdy      = 1'b0;
        vld      = 1'b0;
        inst_out = entry_q.inst;
        accept   = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                rdy = 1'b1;
            end
            ST_WAIT: begin
                rdy = io.inst_data_ok && io.ready_i;
                if (io.inst_data_ok) begin
                    vld      = !io.commit_i;
                    inst_out = io.inst_rdata;
                    if (io.commit_i || io.ready_i) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d      = ST_HOLD;
                        entry_d.inst = io.inst_rdata;
                    end
                end else begin
                    perf_d = perf_q + 32'd1;
                    // A flush while the request is in flight leaves a response that must be swallowed.
                    if (io.commit_i) begin
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_HOLD: begin
                rdy = io.ready_i;
                vld = !io.commit_i;
                if (io.commit_i || io.ready_i) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_DISCARD: begin
                rdy = io.inst_data_ok;
                if (io.inst_data_ok) begin
                    state_d = ST_EMPTY;
                end
            end
        endcase

        accept = io.valid_i && rdy;
        if (accept) begin
            entry_d.pc       = io.pc_i;
            entry_d.exc      = io.exc_i;
            entry_d.exc_miss = io.exc_miss_i;
            entry_d.exccode  = io.exccode_i;
            entry_d.inst     = 32'd0;
            // Flushed entries are dropped; only a real request leaves a response to discard.
            if (io.commit_i || io.cancelled_i) begin
                state_d = io.exc_i ? ST_EMPTY : ST_DISCARD;
            end else begin
                state_d = io.exc_i ? ST_HOLD : ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            entry_q <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            perf_q  <= perf_d;
        end
    end

    assign io.ready_o                = rdy;
    assign io.valid_o                = vld;
    assign io.inst_o                 = inst_out;
    assign io.pc_o                   = entry_q.pc;
    assign io.exc_o                  = entry_q.exc;
    assign io.exc_miss_o             = entry_q.exc_miss;
    assign io.exccode_o              = entry_q.exccode;
    assign io.perfcnt_fetch_waitdata = perf_q;

endmodule
